// File: rtl/parity_pkg.sv
// Shared constants for the streaming parity checker: parity mode encodings and
// the error-counter saturation value.
package parity_pkg;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // All-ones value of a w-bit counter, clipped to 64 bits.
   function automatic logic [63:0] sat_val(input int unsigned w);
      sat_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational parity check of one word: err is 1 when data plus parity bit
// do not match the selected odd/even parity mode.
module parity_reduce
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data,
   input  logic              pb,
   input  logic              mode_odd,
   output logic              err
);

   // Odd mode expects an odd total of ones, so a zero reduction is the error case.
   assign err = (^{data, pb}) ^ (mode_odd == PARITY_ODD);

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker with a one-stage valid/ready pipe, saturating error
// counter and sticky error flag. Define PARITY_CHK_DROP_EN to discard bad words.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_pb,
   input  logic              mode_odd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_error,
   input  logic              clr,
   output logic [CNT_W-1:0]  err_count,
   output logic              err_sticky
);

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_val(CNT_W));

   logic              err;
   logic              acc, xfer;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sticky_q, sticky_d;

   parity_reduce #(.DATA_W(DATA_W)) u_reduce (
      .data     (in_data),
      .pb       (in_pb),
      .mode_odd (mode_odd),
      .err      (err)
   );

   assign in_ready = !vld_q || out_ready;
   assign acc      = in_valid && in_ready;
   assign xfer     = vld_q && out_ready;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      err_d  = err_q;
      if (xfer) vld_d = 1'b0;
`ifdef PARITY_CHK_DROP_EN
      // Bad words are consumed and counted but never reach the pipe register.
      if (acc && !err) begin
         vld_d  = 1'b1;
         data_d = in_data;
      end
`else
      if (acc) begin
         vld_d  = 1'b1;
         data_d = in_data;
         err_d  = err;
      end
`endif
   end

   // Clear takes effect first so a same-cycle error still counts once.
   always_comb begin
      cnt_d    = clr ? '0 : cnt_q;
      sticky_d = clr ? 1'b0 : sticky_q;
      if (acc && err) begin
         sticky_d = 1'b1;
         if (cnt_d != CNT_SAT) cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= 1'b0;
         data_q   <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         data_q   <= data_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign out_valid  = vld_q;
   assign out_data   = data_q;
   assign out_error  = err_q;
   assign err_count  = cnt_q;
   assign err_sticky = sticky_q;

endmodule
